// File: rtl/br_stats_pkg.sv
// Shared definitions for the branch-statistics block: read slot map,
// counter indices and read-FSM state encoding.
package br_stats_pkg;

    localparam logic [2:0] SLOT_BR_LO    = 3'd0;
    localparam logic [2:0] SLOT_BR_HI    = 3'd1;
    localparam logic [2:0] SLOT_HIT_LO   = 3'd2;
    localparam logic [2:0] SLOT_HIT_HI   = 3'd3;
    localparam logic [2:0] SLOT_MISPR_LO = 3'd4;
    localparam logic [2:0] SLOT_MISPR_HI = 3'd5;
    localparam logic [2:0] SLOT_CYC_LO   = 3'd6;
    localparam logic [2:0] SLOT_CYC_HI   = 3'd7;

    typedef enum logic [1:0] {
        CNT_BR    = 2'd0,
        CNT_HIT   = 2'd1,
        CNT_MISPR = 2'd2,
        CNT_CYC   = 2'd3
    } cnt_idx_e;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t RD_IDLE = 1'b0;
    localparam rd_state_t RD_RESP = 1'b1;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; sat flags an increment
// that was dropped because the counter is already at its maximum.
module sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q,
    output logic             sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max_s;

    assign at_max_s = &cnt_q;
    assign sat      = inc & at_max_s;
    assign q        = cnt_q;

    // Next-count: clear dominates, then a non-saturated increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/br_stats.sv
// Branch/BTB statistics counters with a 16-bit slot read port; a lo-slot
// read latches the matching hi half so 32-bit values can be read atomically.
module br_stats
    import br_stats_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_br_cnt,
    input  logic              inc_hit_cnt,
    input  logic              inc_mispr_cnt,
    input  logic              en,
    input  logic              clr,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       rdata,
    output logic              rvalid,
    output logic [3:0]        ovf
);

    logic [3:0]       inc_s;
    logic [3:0]       sat_s;
    logic [CNT_W-1:0] cnt_s [4];
    logic [31:0]      cnt32_s [4];
    logic [31:0]      addr_ext_s;
    logic [31:0]      sel_val_s;
    cnt_idx_e         sel_idx_s;
    logic             sel_hi_s;
    logic             sel_ok_s;

    rd_state_t   state_q, state_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  ovf_q, ovf_d;

    assign inc_s = {en, en & inc_mispr_cnt, en & inc_hit_cnt, en & inc_br_cnt};

    sat_cnt #(.CNT_W(CNT_W)) u_br (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_s[0]), .q(cnt_s[0]), .sat(sat_s[0])
    );
    sat_cnt #(.CNT_W(CNT_W)) u_hit (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_s[1]), .q(cnt_s[1]), .sat(sat_s[1])
    );
    sat_cnt #(.CNT_W(CNT_W)) u_mispr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_s[2]), .q(cnt_s[2]), .sat(sat_s[2])
    );
    sat_cnt #(.CNT_W(CNT_W)) u_cyc (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_s[3]), .q(cnt_s[3]), .sat(sat_s[3])
    );

    // Narrow counters read back zero-extended in their hi slot
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt32_s[i] = 32'(cnt_s[i]);
        end
    end

    assign addr_ext_s = 32'(addr);

    // Slot decode; anything outside the map reads as zero
    always_comb begin
        sel_idx_s = CNT_BR;
        sel_hi_s  = 1'b0;
        sel_ok_s  = 1'b1;
        case (addr_ext_s)
            32'(SLOT_BR_LO):    begin sel_idx_s = CNT_BR;    sel_hi_s = 1'b0; end
            32'(SLOT_BR_HI):    begin sel_idx_s = CNT_BR;    sel_hi_s = 1'b1; end
            32'(SLOT_HIT_LO):   begin sel_idx_s = CNT_HIT;   sel_hi_s = 1'b0; end
            32'(SLOT_HIT_HI):   begin sel_idx_s = CNT_HIT;   sel_hi_s = 1'b1; end
            32'(SLOT_MISPR_LO): begin sel_idx_s = CNT_MISPR; sel_hi_s = 1'b0; end
            32'(SLOT_MISPR_HI): begin sel_idx_s = CNT_MISPR; sel_hi_s = 1'b1; end
            32'(SLOT_CYC_LO):   begin sel_idx_s = CNT_CYC;   sel_hi_s = 1'b0; end
            32'(SLOT_CYC_HI):   begin sel_idx_s = CNT_CYC;   sel_hi_s = 1'b1; end
            default:            sel_ok_s = 1'b0;
        endcase
    end

    assign sel_val_s = cnt32_s[sel_idx_s];

    // Read FSM, response data, shadow capture and sticky overflow
    always_comb begin
        state_d  = RD_IDLE;
        rdata_d  = 16'h0000;
        shadow_d = shadow_q;
        if (re) begin
            state_d = RD_RESP;
            if (!sel_ok_s) begin
                rdata_d = 16'h0000;
            end else if (sel_hi_s) begin
                rdata_d = shadow_q;
            end else begin
                rdata_d  = sel_val_s[15:0];
                shadow_d = sel_val_s[31:16];
            end
        end else begin
            state_d = RD_IDLE;
            rdata_d = 16'h0000;
        end
        // clear still lets this edge's read see the pre-clear value
        if (clr) begin
            shadow_d = 16'h0000;
            ovf_d    = 4'b0000;
        end else begin
            ovf_d    = ovf_q | sat_s;
        end
    end

    // Read-port and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RD_IDLE;
            rdata_q  <= 16'h0000;
            shadow_q <= 16'h0000;
            ovf_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = (state_q == RD_RESP);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_br_stats.sv
// Directed bench for br_stats: stimulus queues expected read data, an
// independent monitor pops and compares on every rvalid.
module tb_br_stats;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc_br_cnt = 1'b0;
    logic        inc_hit_cnt = 1'b0;
    logic        inc_mispr_cnt = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        re = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [15:0] rdata;
    logic        rvalid;
    logic [3:0]  ovf;

    typedef struct packed {
        logic [2:0]  slot;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   run_cnt = 0;
    int   last_run = 0;

    br_stats dut (
        .clk(clk), .rst_n(rst_n), .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt),
        .inc_mispr_cnt(inc_mispr_cnt), .en(en), .clr(clr), .re(re), .addr(addr),
        .rdata(rdata), .rvalid(rvalid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Single read: one cycle of re, then one idle cycle
    task automatic rd(input logic [2:0] a, input logic [15:0] want);
        re = 1'b1;
        addr = a;
        exp_q.push_back('{slot: a, data: want});
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compare every response against the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rvalid === 1'b1) begin
                run_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_rvalid", 32'(rvalid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("rd_slot%0d", e.slot), 32'(rdata), 32'(e.data));
                end
            end else begin
                if (run_cnt != 0) last_run = run_cnt;
                run_cnt = 0;
                chk("rdata_idle", 32'(rdata), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ten branches
        en = 1'b1; inc_br_cnt = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0; inc_br_cnt = 1'b0;
        rd(3'd0, 16'h000A);
        chk("single_rvalid_len", 32'(last_run), 32'd1);
        rd(3'd6, 16'h000A);
        rd(3'd7, 16'h0000);
        rd(3'd2, 16'h0000);

        // carry into the hi half
        force dut.u_br.cnt_q = 32'h0001FFFF;
        @(negedge clk);
        release dut.u_br.cnt_q;
        en = 1'b1; inc_br_cnt = 1'b1;
        @(negedge clk);
        en = 1'b0; inc_br_cnt = 1'b0;
        rd(3'd0, 16'h0000);
        rd(3'd1, 16'h0002);
        chk("ovf_no_sat", 32'(ovf), 32'd0);

        // saturation and sticky overflow
        force dut.u_br.cnt_q = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.u_br.cnt_q;
        en = 1'b1; inc_br_cnt = 1'b1;
        @(negedge clk);
        en = 1'b0; inc_br_cnt = 1'b0;
        chk("ovf_br_set", 32'(ovf), 32'h1);
        rd(3'd0, 16'hFFFF);
        rd(3'd1, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        rd(3'd0, 16'h0000);
        rd(3'd1, 16'h0000);
        rd(3'd6, 16'h0000);

        // clr beats a same-cycle increment
        en = 1'b1; inc_hit_cnt = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0; inc_hit_cnt = 1'b0;
        rd(3'd2, 16'h0003);
        en = 1'b1; inc_hit_cnt = 1'b1; clr = 1'b1;
        @(negedge clk);
        en = 1'b0; inc_hit_cnt = 1'b0; clr = 1'b0;
        rd(3'd2, 16'h0000);
        rd(3'd6, 16'h0000);

        // counters hold while disabled
        en = 1'b1; inc_br_cnt = 1'b1; inc_hit_cnt = 1'b1; inc_mispr_cnt = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        rd(3'd0, 16'h0004);
        rd(3'd2, 16'h0004);
        rd(3'd4, 16'h0004);
        rd(3'd6, 16'h0004);
        inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;

        // back-to-back burst 6,7,2 and shadow sharing across counters
        force dut.u_cyc.cnt_q = 32'h0003FFFE;
        @(negedge clk);
        release dut.u_cyc.cnt_q;
        re = 1'b1; addr = 3'd6; exp_q.push_back('{slot: 3'd6, data: 16'hFFFE});
        @(negedge clk);
        addr = 3'd7; exp_q.push_back('{slot: 3'd7, data: 16'h0003});
        @(negedge clk);
        addr = 3'd2; exp_q.push_back('{slot: 3'd2, data: 16'h0004});
        @(negedge clk);
        re = 1'b0;
        repeat (2) @(negedge clk);
        chk("burst_rvalid_len", 32'(last_run), 32'd3);
        rd(3'd5, 16'h0000);
        rd(3'd6, 16'hFFFE);
        rd(3'd3, 16'h0003);

        // clr during a lo read: pre-clear data, shadow cleared
        clr = 1'b1; re = 1'b1; addr = 3'd6;
        exp_q.push_back('{slot: 3'd6, data: 16'hFFFE});
        @(negedge clk);
        clr = 1'b0; re = 1'b0;
        @(negedge clk);
        rd(3'd7, 16'h0000);
        rd(3'd6, 16'h0000);
        rd(3'd0, 16'h0000);

        // reset in the middle of a read burst
        en = 1'b1; inc_br_cnt = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0; inc_br_cnt = 1'b0;
        re = 1'b1; addr = 3'd0;
        exp_q.push_back('{slot: 3'd0, data: 16'h0002});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", 32'(rvalid), 32'd0);
        chk("async_rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rd(3'd0, 16'h0000);
        rd(3'd6, 16'h0000);
        chk("final_ovf", 32'(ovf), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
